prince_sbox_glm_pipe: RTL and testbench
=======================================

// Module: prince_sbox_glm_pipe
// PURPOSE
// - Pipelined, two-share (d=1) glitch-robust PRINCE S-box layer over NIBBLES parallel nibbles.
// - Stage 1 evaluates the 16 share-domain component functions per nibble and registers them.
//   Domain d, bit i, selects share d[i] of input bit i; no domain mixes both shares of one bit.
// - Stage 2 compresses the registered domain terms into two output shares.
// - Sits between the masked key/round-constant add and the masked M-layer in the round datapath.
// PARAMETERS
// - NIBBLES  16  number of parallel 4-bit S-box lanes; legal range 1..16
// PORTS
// - clk        in   1           clock, rising edge
// - rst_n      in   1           asynchronous reset, active low
// - in_valid   in   1           input shares valid
// - in_ready   out  1           block accepts input this cycle
// - in_sh0     in   4*NIBBLES   input share 0; nibble k is bits [4k+3:4k]
// - in_sh1     in   4*NIBBLES   input share 1
// - out_valid  out  1           output shares valid
// - out_ready  in   1           consumer accepts output
// - out_sh0    out  4*NIBBLES   output share 0
// - out_sh1    out  4*NIBBLES   output share 1
// - rnd        in   4*NIBBLES   fresh randomness; present only with PRINCE_SBOX_REFRESH_EN
// BEHAVIOUR
// - Function: per nibble, out_sh0^out_sh1 == S(in_sh0^in_sh1).
//   S = {B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4}, indexed by input value 0..F.
// - Domain terms: write each S output bit in ANF. A monomial over bit set m appears once for
//   each share assignment of m. That instance is evaluated only in the domain whose bits
//   outside m are 0. Constant terms go to domain 0.
// - Compression: domain terms with even popcount(d) XOR into share 0; odd popcount into share 1.
// - Stage 1 register: 16 domain results x 4 bits per nibble, plus s1_valid.
//   Loads only on an input transfer (in_valid & in_ready); otherwise holds.
// - Stage 2 register: out_sh0, out_sh1 and out_valid. Loads only when stage 1 advances.
// - Latency: exactly 2 cycles from input transfer to out_valid with no stall.
//   Throughput 1 per cycle.
// - Handshake:
//   - s2_adv   = s1_valid & (~out_valid | out_ready).
//   - in_ready = ~s1_valid | s2_adv.
//   - out_valid drops after a transfer when no new data is advanced.
//   - Output data is stable while out_valid & ~out_ready.
// - Simultaneous output transfer and s2_adv in one cycle: new data replaces old; no bubble.
// - Full: both stages valid and out_ready=0. Then in_ready=0 and all registers hold.
// - Empty: s1_valid=out_valid=0 and in_ready=1.
// - Reset (async, any cycle including mid-flight):
//   - s1_valid, out_valid and all data registers go to 0.
//   - out_sh0=out_sh1=0 and in_ready=1 after reset release.
//   - In-flight data is discarded.
// - No combinational path from in_* to out_*. out_ready to in_ready is combinational.
// CONFIGURATION
// - PRINCE_SBOX_REFRESH_EN defined:
//   - rnd port exists and is sampled with the stage 1 advance (s2_adv).
//   - rnd nibble k is XORed into both out_sh0[k] and out_sh1[k] at the stage 2 load.
//   - Unshared value unchanged; latency unchanged.
// - PRINCE_SBOX_REFRESH_EN undefined: no rnd port; outputs are the plain compression result.
// TESTING
// - Reset, then NIBBLES=16, in_sh0=in_sh1=0, in_valid=1, out_ready=1.
//   -> 2 cycles later out_valid=1 and out_sh0^out_sh1=0xBBBB_BBBB_BBBB_BBBB.
// - Nibble 0 with in_sh0=0x5, in_sh1=0xF (x=0xA) -> nibble 0 of out_sh0^out_sh1 = 0x8.
//   Sweep all 256 share pairs on every lane, checking against S.
// - Stream 8 words with out_ready=0 from cycle 3.
//   -> in_ready=0 once both stages are full; outputs hold.
//   -> After out_ready=1: all 8 words appear in order, no loss or duplication.
// - Toggle out_ready every cycle under continuous in_valid.
//   -> Transfers occur only when valid&ready; output order is preserved.
// - Assert rst_n=0 while both stages are valid -> immediately out_valid=0, outputs 0.
//   -> First word after release still has 2-cycle latency.
// - With PRINCE_SBOX_REFRESH_EN, in_sh0=in_sh1=0, rnd=all 0xF:
//   -> each output share differs by 0xF from the non-refresh build.
//   -> XOR of shares still 0xB per lane.

Source files
------------

// File: rtl/prince_sbox_glm_pipe.sv
// Two-stage, two-share glitch-robust PRINCE S-box layer over NIBBLES lanes.
// Optional output refresh with fresh randomness: define PRINCE_SBOX_REFRESH_EN.
module prince_sbox_glm_pipe #(
    parameter int unsigned NIBBLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_sh0,
    input  logic [4*NIBBLES-1:0]   in_sh1,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sh0,
    output logic [4*NIBBLES-1:0]   out_sh1
`ifdef PRINCE_SBOX_REFRESH_EN
    ,
    input  logic [4*NIBBLES-1:0]   rnd
`endif
);

    localparam int unsigned W = 4 * NIBBLES;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hB;  4'h1: y = 4'hF;  4'h2: y = 4'h3;  4'h3: y = 4'h2;
            4'h4: y = 4'hA;  4'h5: y = 4'hC;  4'h6: y = 4'h9;  4'h7: y = 4'h1;
            4'h8: y = 4'h6;  4'h9: y = 4'h7;  4'hA: y = 4'h8;  4'hB: y = 4'h0;
            4'hC: y = 4'hE;  4'hD: y = 4'h5;  4'hE: y = 4'hD;  default: y = 4'h4;
        endcase
        return y;
    endfunction

    // ANF coefficients via Moebius transform; bit j*16+m is monomial m of output bit j.
    function automatic logic [63:0] anf_table();
        logic [63:0] a;
        logic [3:0]  s;
        logic        c;
        a = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            for (int unsigned m = 0; m < 16; m++) begin
                c = 1'b0;
                for (int unsigned u = 0; u < 16; u++) begin
                    if ((u & ~m) == 0) begin
                        s = sbox(4'(u));
                        c = c ^ s[j];
                    end
                end
                a[j*16+m] = c;
            end
        end
        return a;
    endfunction

    localparam logic [63:0] ANF = anf_table();

    // Domain d evaluates only monomial instances whose bits outside m select share 0,
    // so every instance lands in exactly one domain and no domain sees both shares of a bit.
    function automatic logic [63:0] dom_terms(input logic [3:0] s0, input logic [3:0] s1);
        logic [63:0] t;
        logic [3:0]  dv;
        logic [3:0]  mv;
        logic        p;
        t = '0;
        for (int unsigned d = 0; d < 16; d++) begin
            dv = 4'(d);
            for (int unsigned j = 0; j < 4; j++) begin
                for (int unsigned m = 0; m < 16; m++) begin
                    mv = 4'(m);
                    if (ANF[j*16+m] && ((dv & ~mv) == 4'b0000)) begin
                        p = 1'b1;
                        for (int unsigned i = 0; i < 4; i++) begin
                            if (mv[i]) p = p & (dv[i] ? s1[i] : s0[i]);
                        end
                        t[d*4+j] = t[d*4+j] ^ p;
                    end
                end
            end
        end
        return t;
    endfunction

    function automatic logic [7:0] compress(input logic [63:0] dom);
        logic [3:0] sh0;
        logic [3:0] sh1;
        logic [3:0] dv;
        sh0 = '0;
        sh1 = '0;
        for (int unsigned d = 0; d < 16; d++) begin
            dv = 4'(d);
            if (^dv) sh1 = sh1 ^ dom[d*4 +: 4];
            else     sh0 = sh0 ^ dom[d*4 +: 4];
        end
        return {sh1, sh0};
    endfunction

    logic [NIBBLES*64-1:0] w_dom;
    logic [NIBBLES*64-1:0] r_dom;
    logic [W-1:0]          w_c_sh0;
    logic [W-1:0]          w_c_sh1;
    logic [W-1:0]          w_nxt_sh0;
    logic [W-1:0]          w_nxt_sh1;
    logic                  r_s1_valid;
    logic                  r_out_valid;
    logic [W-1:0]          r_out_sh0;
    logic [W-1:0]          r_out_sh1;
    logic                  w_s2_adv;
    logic                  w_in_xfer;

    for (genvar k = 0; k < NIBBLES; k++) begin : g_lane
        assign w_dom[k*64 +: 64] = dom_terms(in_sh0[4*k +: 4], in_sh1[4*k +: 4]);
        assign {w_c_sh1[4*k +: 4], w_c_sh0[4*k +: 4]} = compress(r_dom[k*64 +: 64]);
    end

`ifdef PRINCE_SBOX_REFRESH_EN
    assign w_nxt_sh0 = w_c_sh0 ^ rnd;
    assign w_nxt_sh1 = w_c_sh1 ^ rnd;
`else
    assign w_nxt_sh0 = w_c_sh0;
    assign w_nxt_sh1 = w_c_sh1;
`endif

    assign w_s2_adv  = r_s1_valid & (~r_out_valid | out_ready);
    assign in_ready  = ~r_s1_valid | w_s2_adv;
    assign w_in_xfer = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_dom      <= '0;
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
            r_dom      <= w_dom;
        end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sh0   <= '0;
            r_out_sh1   <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= 1'b1;
            r_out_sh0   <= w_nxt_sh0;
            r_out_sh1   <= w_nxt_sh1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sh0   = r_out_sh0;
    assign out_sh1   = r_out_sh1;

endmodule

// File: tb/tb_prince_sbox_glm_pipe.sv
// Scoreboard bench for prince_sbox_glm_pipe (NIBBLES=16): S-box table model,
// latency, backpressure, hold, mid-flight reset.
module tb_prince_sbox_glm_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_sh0;
    logic [63:0] in_sh1;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sh0;
    logic [63:0] out_sh1;
`ifdef PRINCE_SBOX_REFRESH_EN
    logic [63:0] rnd = '0;
    always @(negedge clk) rnd = {$urandom, $urandom};
`endif

    int tests = 0;
    int fails = 0;
    logic [63:0] q[$];

    logic [3:0] SBOX [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                              4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};

    prince_sbox_glm_pipe #(.NIBBLES(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sh0    (in_sh0),
        .in_sh1    (in_sh1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sh0   (out_sh0),
        .out_sh1   (out_sh1)
`ifdef PRINCE_SBOX_REFRESH_EN
        ,
        .rnd       (rnd)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [63:0] x);
        logic [63:0] r;
        logic [3:0]  n;
        for (int k = 0; k < 16; k++) begin
            n = x[4*k +: 4];
            r[4*k +: 4] = SBOX[n];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected values are queued at the moment an input transfer is seen.
    always @(negedge clk) begin
        #4;
        if (rst_n === 1'b1 && in_valid && in_ready)
            q.push_back(model(in_sh0 ^ in_sh1));
    end

    logic        hold_pend = 1'b0;
    logic [128:0] held;
    always @(negedge clk) begin
        logic [63:0] exp;
        #4;
        if (rst_n !== 1'b1) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                tests++;
                if ({out_valid, out_sh0, out_sh1} !== held) begin
                    fails++;
                    $display("FAIL hold_stable: got %h expected %h", {out_valid, out_sh0, out_sh1}, held);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: got %h expected no output", out_sh0 ^ out_sh1);
                end else begin
                    exp = q.pop_front();
                    if ((out_sh0 ^ out_sh1) !== exp) begin
                        fails++;
                        $display("FAIL data: got %h expected %h", out_sh0 ^ out_sh1, exp);
                    end
                end
            end
            hold_pend = out_valid && !out_ready;
            held = {1'b1, out_sh0, out_sh1};
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [63:0] s0, input logic [63:0] s1);
        bit done = 0;
        in_sh0 = s0;
        in_sh1 = s1;
        in_valid = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            #4;
            if (in_ready) done = 1;
            @(negedge clk);
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 100 cycles");
            in_valid = 1'b0;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic check_latency(input logic [63:0] s0, input logic [63:0] s1);
        in_sh0 = s0;
        in_sh1 = s1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #4 chk("lat_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #4 chk("lat_1cycle_out_valid", out_valid, 0);
        @(negedge clk);
        #4 chk("lat_2cycle_out_valid", out_valid, 1);
        @(negedge clk);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_sh0"}, out_sh0, 0);
        chk({tag, "_out_sh1"}, out_sh1, 0);
    endtask

    initial begin
        logic [63:0] s0, s1;
        logic [7:0]  p;
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_sh0 = '0;
        in_sh1 = '0;
        #2 rst_n = 1'b0;
        #1 reset_checks("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        check_latency(64'h0, 64'h0);

        send(64'h5, 64'hF);
        idle();

        for (int j = 0; j < 256; j++) begin
            for (int k = 0; k < 16; k++) begin
                p = 8'(j + 17 * k);
                s0[4*k +: 4] = p[7:4];
                s1[4*k +: 4] = p[3:0];
            end
            send(s0, s1);
        end
        idle();
        repeat (3) @(negedge clk);

        fork
            begin
                for (int i = 0; i < 8; i++) send({$urandom, $urandom}, {$urandom, $urandom});
                idle();
            end
            begin
                repeat (2) @(negedge clk);
                out_ready = 1'b0;
                repeat (10) @(negedge clk);
                #4;
                chk("full_in_ready", in_ready, 0);
                chk("full_out_valid", out_valid, 1);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);

        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    out_ready = ~out_ready;
                end
            end
            begin
                for (int i = 0; i < 20; i++) send({$urandom, $urandom}, {$urandom, $urandom});
                idle();
            end
        join
        out_ready = 1'b1;
        repeat (4) @(negedge clk);

        out_ready = 1'b0;
        send({$urandom, $urandom}, {$urandom, $urandom});
        send({$urandom, $urandom}, {$urandom, $urandom});
        idle();
        #1 chk("pre_reset_full", {62'b0, out_valid, in_ready}, 64'h2);
        #1 rst_n = 1'b0;
        #1 reset_checks("midflight_reset");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        check_latency({$urandom, $urandom}, {$urandom, $urandom});

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
